// File: rtl/io_port_bridge.sv
// Host-side I/O port bridge: an input FIFO feeds the CPU I port, an output FIFO captures the CPU O port.
// Define IO_STATS_EN to build the saturating rd/wr/stall counters; otherwise those ports read as zero.
module io_port_bridge #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_IEnable,
  output logic [DATA_W-1:0]        cpu_I,
  input  logic                     cpu_OEnable,
  input  logic [DATA_W-1:0]        cpu_O,
  output logic                     cpu_wait,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   in_level,
  output logic                     underflow,
  output logic [CNT_W-1:0]         rd_count,
  output logic [CNT_W-1:0]         wr_count,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] in_mem  [DEPTH];
  logic [DATA_W-1:0] out_mem [DEPTH];
  logic [PTR_W-1:0]  in_wptr, in_rptr;
  logic [PTR_W-1:0]  out_wptr, out_rptr;
  logic [LVL_W-1:0]  out_level;

  logic in_empty, in_full, in_push, in_pop;
  logic out_empty, out_full, out_push, out_pop;

  assign in_empty  = (in_level == '0);
  assign in_full   = (in_level == FULL_LVL);
  assign out_empty = (out_level == '0);
  assign out_full  = (out_level == FULL_LVL);

  // No pass-through in either direction: a full FIFO refuses writers even if a reader pops this cycle.
  assign in_ready  = !in_full;
  assign in_push   = in_valid && !in_full;
  assign in_pop    = cpu_IEnable && !in_empty;
  assign out_push  = cpu_OEnable && !out_full;
  assign out_pop   = !out_empty && out_ready;

  assign cpu_I     = in_empty  ? '0 : in_mem[in_rptr];
  assign out_data  = out_empty ? '0 : out_mem[out_rptr];
  assign out_valid = !out_empty;
  assign cpu_wait  = (cpu_IEnable && in_empty) || (cpu_OEnable && out_full);

  always_ff @(posedge clk) begin
    if (!rst && in_push)
      in_mem[in_wptr] <= in_data;
    if (!rst && out_push)
      out_mem[out_wptr] <= cpu_O;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wptr  <= '0;
      in_rptr  <= '0;
      in_level <= '0;
    end else begin
      if (in_push)
        in_wptr <= in_wptr + PTR_W'(1);
      if (in_pop)
        in_rptr <= in_rptr + PTR_W'(1);
      case ({in_push, in_pop})
        2'b10:   in_level <= in_level + LVL_W'(1);
        2'b01:   in_level <= in_level - LVL_W'(1);
        default: in_level <= in_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_level <= '0;
    end else begin
      if (out_push)
        out_wptr <= out_wptr + PTR_W'(1);
      if (out_pop)
        out_rptr <= out_rptr + PTR_W'(1);
      case ({out_push, out_pop})
        2'b10:   out_level <= out_level + LVL_W'(1);
        2'b01:   out_level <= out_level - LVL_W'(1);
        default: out_level <= out_level;
      endcase
    end
  end

  // Sticky until reset so software can discover a read that stalled on an empty port.
  always_ff @(posedge clk) begin
    if (rst)
      underflow <= 1'b0;
    else if (cpu_IEnable && in_empty)
      underflow <= 1'b1;
  end

`ifdef IO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (in_pop && rd_count != '1)
        rd_count <= rd_count + CNT_W'(1);
      if (out_push && wr_count != '1)
        wr_count <= wr_count + CNT_W'(1);
      if (cpu_wait && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`else
  assign rd_count    = '0;
  assign wr_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed and random traffic checked each cycle against a queue-based model.
module tb_io_port_bridge;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef IO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cpu_IEnable, cpu_OEnable, in_valid, out_ready;
  logic [DATA_W-1:0] cpu_O, in_data;
  logic [DATA_W-1:0] cpu_I, out_data;
  logic              cpu_wait, in_ready, out_valid, underflow;
  logic [LVL_W-1:0]  in_level;
  logic [CNT_W-1:0]  rd_count, wr_count, stall_count;

  logic              sat_rst, sat_ie, sat_iv;
  logic [DATA_W-1:0] sat_id;
  logic [DATA_W-1:0] sat_cpu_I, sat_out_data;
  logic              sat_wait, sat_in_ready, sat_out_valid, sat_underflow;
  logic [LVL_W-1:0]  sat_level;
  logic [3:0]        sat_rd, sat_wr, sat_stall;

  io_port_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_IEnable(cpu_IEnable), .cpu_I(cpu_I),
    .cpu_OEnable(cpu_OEnable), .cpu_O(cpu_O), .cpu_wait(cpu_wait),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_level(in_level), .underflow(underflow),
    .rd_count(rd_count), .wr_count(wr_count), .stall_count(stall_count)
  );

  io_port_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) sat_dut (
    .clk(clk), .rst(sat_rst),
    .cpu_IEnable(sat_ie), .cpu_I(sat_cpu_I),
    .cpu_OEnable(1'b0), .cpu_O(8'h00), .cpu_wait(sat_wait),
    .in_data(sat_id), .in_valid(sat_iv), .in_ready(sat_in_ready),
    .out_data(sat_out_data), .out_valid(sat_out_valid), .out_ready(1'b0),
    .in_level(sat_level), .underflow(sat_underflow),
    .rd_count(sat_rd), .wr_count(sat_wr), .stall_count(sat_stall)
  );

  // Reference model: byte queues plus unsaturated event totals.
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] out_q[$];
  bit     m_underflow;
  longint m_rd, m_wr, m_stall;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] statExp(longint v, int w);
    longint maxv = (longint'(1) << w) - 1;
    if (!STATS) return 32'd0;
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit expWait;
    expWait = (cpu_IEnable && in_q.size() == 0) || (cpu_OEnable && out_q.size() == DEPTH);
    chk("cpu_I",       32'(cpu_I),       (in_q.size() != 0) ? 32'(in_q[0]) : 32'd0);
    chk("in_ready",    32'(in_ready),    32'(in_q.size() != DEPTH));
    chk("in_level",    32'(in_level),    32'(in_q.size()));
    chk("out_valid",   32'(out_valid),   32'(out_q.size() != 0));
    chk("out_data",    32'(out_data),    (out_q.size() != 0) ? 32'(out_q[0]) : 32'd0);
    chk("cpu_wait",    32'(cpu_wait),    32'(expWait));
    chk("underflow",   32'(underflow),   32'(m_underflow));
    chk("rd_count",    32'(rd_count),    statExp(m_rd, CNT_W));
    chk("wr_count",    32'(wr_count),    statExp(m_wr, CNT_W));
    chk("stall_count", 32'(stall_count), statExp(m_stall, CNT_W));
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance the model, step past the edge.
  task automatic applyStimulus(bit ie, bit oe, logic [7:0] o, bit iv, logic [7:0] id, bit ordy);
    bit inEmpty, inFull, outEmpty, outFull;
    cpu_IEnable = ie; cpu_OEnable = oe; cpu_O = o;
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    checkOutput();
    inEmpty  = (in_q.size() == 0);
    inFull   = (in_q.size() == DEPTH);
    outEmpty = (out_q.size() == 0);
    outFull  = (out_q.size() == DEPTH);
    if ((ie && inEmpty) || (oe && outFull)) m_stall++;
    if (ie && inEmpty) m_underflow = 1'b1;
    if (ie && !inEmpty) begin void'(in_q.pop_front()); m_rd++; end
    if (iv && !inFull) in_q.push_back(id);
    if (ordy && !outEmpty) void'(out_q.pop_front());
    if (oe && !outFull) begin out_q.push_back(o); m_wr++; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    cpu_IEnable = 1'b0; cpu_OEnable = 1'b0; cpu_O = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_q.delete(); out_q.delete();
    m_underflow = 1'b0; m_rd = 0; m_wr = 0; m_stall = 0;
    #1;
    checkOutput();
  endtask

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    sat_rst = 1'b1; sat_ie = 1'b0; sat_iv = 1'b0; sat_id = '0;
    @(negedge clk);
    doReset();

    // Ordered delivery of three host bytes to the CPU.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, seq[i], 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);

    // Read on empty, then underflow must survive later good reads.
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 1, 8'h5A, 0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);

    // Output FIFO overflow and drain.
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 8'(8'hA0 + i), 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hEE, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);

    // Input FIFO full with simultaneous CPU pop.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 8'h00, 1, 8'(8'hC0 + i), 0);
    applyStimulus(1, 0, 8'h00, 1, 8'hCF, 0);
    applyStimulus(0, 0, 8'h00, 1, 8'hD0, 0);

    // Reset mid-transfer discards everything.
    applyStimulus(0, 1, 8'h77, 0, 8'h00, 0);
    doReset();

    // Wrap: level held at 3 across 20 concurrent push/pop cycles.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 8'h00, 1, 8'($urandom), 0);
    chk("wrap_level", 32'(in_level), 32'd3);

    // Stats scenario: 5 reads, 4 writes, 2 stall cycles from a clean start.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h70 + i), 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
    chk("stats_rd",    32'(rd_count),    STATS ? 32'd5 : 32'd0);
    chk("stats_wr",    32'(wr_count),    STATS ? 32'd4 : 32'd0);
    chk("stats_stall", 32'(stall_count), STATS ? 32'd2 : 32'd0);

    // Random traffic, first producer-heavy then consumer-heavy.
    for (int i = 0; i < 150; i++)
      applyStimulus(($urandom % 4) == 0, ($urandom % 4) != 0, 8'($urandom),
                    ($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0);
    for (int i = 0; i < 150; i++)
      applyStimulus(($urandom % 4) != 0, ($urandom % 4) == 0, 8'($urandom),
                    ($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0);

    // Saturation on a 4-bit counter instance: 16 reads leave rd_count at 15.
    @(negedge clk);
    sat_rst = 1'b0;
    sat_iv = 1'b1; sat_id = 8'h01;
    @(negedge clk);
    sat_ie = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sat_id = 8'(i + 2);
      @(negedge clk);
    end
    sat_ie = 1'b0; sat_iv = 1'b0;
    #1;
    chk("sat_rd_count", 32'(sat_rd), STATS ? 32'd15 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
